tap_sample_reader: RTL
======================

Name: tap_sample_reader

Overview:
- Per-band sample history reader for the serial FIR MAC in the 8-band equalizer.
- Stores the last DEPTH input samples in a circular buffer, written once per audio sample.
- After each accepted sample, streams the taps newest-to-oldest, one per clk: x[n], x[n-1], …, x[n-DEPTH+1].
- Replaces shift-register history on the read side: one write per sample, one sequential read burst per sample.

Parameters:
- DATA_W, 16: sample width; signed fixed-point Q1.15, range [-1, 1).
- DEPTH, 64: number of taps per burst. Must be a power of 2 and at least 2.
- IDX_W, 6: tap index width. Must equal log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_sample_valid  in  1  single-cycle strobe: new input sample present
- i_signal_sample  in  DATA_W  signed input sample
- o_tap_sample  out  DATA_W  signed tap sample, registered
- o_tap_index  out  IDX_W  tap number k of o_tap_sample (0 = newest)
- o_tap_valid  out  1  o_tap_sample and o_tap_index are valid this cycle
- o_frame_done  out  1  single-cycle pulse on the last tap (k = DEPTH-1)
- o_busy  out  1  read burst in progress; new samples are not accepted
- o_overrun  out  1  sticky: a sample arrived while busy; cleared only by rst

Behaviour:
- Reset (synchronous, takes effect at the next clk edge):
  - All outputs go to 0.
  - Every buffer entry goes to 0.
  - wr_ptr goes to 0.
  - FSM goes to IDLE.
  - Reset applied mid-burst aborts the burst: o_tap_valid is 0 on the cycle after the rst edge, and no o_frame_done pulse is issued.
- FSM states are IDLE and READ. o_busy is 1 exactly when the state is READ.
- IDLE -> READ when i_sample_valid = 1 at edge T:
  - mem[wr_ptr] <= i_signal_sample.
  - The written slot is latched as the burst base, newest = wr_ptr.
  - wr_ptr <= (wr_ptr + 1) mod DEPTH.
  - k <= 0.
- READ:
  - At each edge T+1+k, for k = 0..DEPTH-1, the registered outputs load:
    - o_tap_sample = mem[(newest - k) mod DEPTH]
    - o_tap_index = k
    - o_tap_valid = 1
  - Taps are therefore visible during cycles T+1 .. T+DEPTH. Latency from the strobe to tap 0 is 1 cycle.
  - Tap 0 equals the sample just written. Forward it (bypass) if the write and the read collide in the same cycle.
  - o_frame_done = 1 only together with k = DEPTH-1.
  - The state returns to IDLE when k = DEPTH-1 is issued. o_busy drops in the cycle after the last tap.
- Accepting and rejecting samples:
  - A sample is accepted only when o_busy = 0. The earliest back-to-back accept is therefore one cycle after the last tap.
  - i_sample_valid while o_busy = 1: the sample is dropped, the buffer and wr_ptr are unchanged, the burst continues unaffected, and o_overrun <= 1.
- Outside bursts: o_tap_valid = 0 and o_frame_done = 0. o_tap_sample and o_tap_index hold their last values.
- Arithmetic:
  - All pointer and index arithmetic is unsigned IDX_W-bit with natural wrap-around modulo DEPTH.
  - No sample arithmetic is performed. Samples pass through bit-exact, signedness preserved.
- Warm-up: before DEPTH samples have been written, the older taps read 0, the reset contents of the buffer.

Decomposition:
- Shared equalizer package/header: SAMPLE_W = 16, NUM_TAPS = 64, TAP_IDX_W = 6, the signed sample type, and the FSM state encoding (IDLE, READ).
- One sub-module, tap_history_ram:
  - DEPTH x DATA_W register array.
  - One synchronous write port and one combinational read port.
  - Synchronous clear on rst.
- The FSM, the pointers, the bypass path and the output registers live in the top level.

Test Plan:
- Reset, then one sample 0x1234 -> taps k = 0..63 in 64 consecutive cycles starting 1 cycle after the strobe: tap0 = 0x1234, taps 1..63 = 0x0000; o_frame_done only with k = 63.
- Write samples 1..70 (value = sample number), each strobe issued after the previous burst ends -> in the burst for sample 70, tap k = 70-k for k = 0..63 (tap63 = 7); covers wr_ptr wrap.
- Negative values 0x8000 then 0xFFFF -> tap0 = 0xFFFF and tap1 = 0x8000, bit-exact.
- Strobe at tap k = 10 of a burst -> o_overrun = 1 and stays 1; the burst still outputs all 64 taps; the next accepted sample's burst shows the dropped value absent.
- Strobe on the cycle right after o_frame_done -> accepted; the new burst's tap0 appears 1 cycle later (back-to-back throughput).
- rst asserted at tap k = 30 -> o_tap_valid, o_busy and o_overrun are 0 the next cycle; no o_frame_done; the next sample's burst shows only that sample, all other taps 0.

Source files
------------

// File: rtl/tap_sample_reader_pkg.sv
// Shared equalizer definitions: sample format, tap count and the tap reader FSM encoding.
package tap_sample_reader_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int NUM_TAPS  = 64;
  localparam int TAP_IDX_W = 6;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

endpackage

// File: rtl/tap_history_ram.sv
// Sample history storage: one synchronous write port, one combinational read port,
// synchronously cleared so warm-up taps read as zero.
module tap_history_ram
  import tap_sample_reader_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = NUM_TAPS,
  parameter int IDX_W  = TAP_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tap_sample_reader.sv
// Per-band FIR history reader: stores each accepted sample in a circular buffer and
// then streams the taps newest-to-oldest, one per clock, to the serial MAC.
module tap_sample_reader
  import tap_sample_reader_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = NUM_TAPS,
  parameter int IDX_W  = TAP_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_signal_sample,
  output logic [DATA_W-1:0] o_tap_sample,
  output logic [IDX_W-1:0]  o_tap_index,
  output logic              o_tap_valid,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  newest_q;
  logic [IDX_W-1:0]  k_q;
  logic              accept;
  logic              last_tap;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tap_data;

  tap_history_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_history (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (i_signal_sample),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_tap = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sample_valid) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (k_q == LAST_K) begin
          last_tap = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Forward the incoming sample if it targets the slot being read this cycle.
  assign rd_addr  = newest_q - k_q;
  assign tap_data = (accept && (wr_ptr_q == rd_addr)) ? i_signal_sample : rd_data;

  assign o_busy = (state_q == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      newest_q     <= '0;
      k_q          <= '0;
      o_tap_sample <= '0;
      o_tap_index  <= '0;
      o_tap_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_tap_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      if (accept) begin
        newest_q <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_q + IDX_W'(1);
        k_q      <= '0;
      end
      if (state_q == READ) begin
        o_tap_sample <= tap_data;
        o_tap_index  <= k_q;
        o_tap_valid  <= 1'b1;
        o_frame_done <= last_tap;
        k_q          <= k_q + IDX_W'(1);
        if (i_sample_valid) o_overrun <= 1'b1;
      end
    end
  end

endmodule
